cva6_lsu_mo_model: RTL

CVA6_LSU_MO_MODEL -- requirements
Module: cva6_lsu_mo_model

---
 rtl/cva6_lsu_mo_model.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cva6_lsu_mo_model.sv
// Outstanding load/store tracker with RAW detection against pending stores.
// Define LSU_MO_MODEL_ERR_EN to enable sticky protocol error reporting.
module cva6_lsu_mo_model #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned LD_DEPTH = 2,
  parameter int unsigned ST_DEPTH = 2
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [31:0]                   instr_i,
  input  logic                          is_load_i,
  input  logic                          instr_valid_i,
  input  logic                          load_mem_resp_i,
  input  logic                          store_mem_resp_i,
  output logic                          ready_o,
  output logic [$clog2(LD_DEPTH+1)-1:0] ld_cnt_o,
  output logic [$clog2(ST_DEPTH+1)-1:0] st_cnt_o,
  output logic                          ld_head_valid_o,
  output logic [ADDR_W-1:0]             ld_head_addr_o,
  output logic                          st_head_valid_o,
  output logic [ADDR_W-1:0]             st_head_addr_o,
  output logic                          raw_hit_o,
  output logic                          error_o
);

  localparam int unsigned LCW = $clog2(LD_DEPTH+1);
  localparam int unsigned SCW = $clog2(ST_DEPTH+1);
  localparam int unsigned LPW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
  localparam int unsigned SPW = (ST_DEPTH > 1) ? $clog2(ST_DEPTH) : 1;
  localparam logic [LPW-1:0] LD_LAST = LPW'(LD_DEPTH-1);
  localparam logic [SPW-1:0] ST_LAST = SPW'(ST_DEPTH-1);

  logic [LCW-1:0]    ld_cnt;
  logic [SCW-1:0]    st_cnt;
  logic [LPW-1:0]    ld_rd;
  logic [LPW-1:0]    ld_wr;
  logic [SPW-1:0]    st_rd;
  logic [SPW-1:0]    st_wr;
  logic [ADDR_W-1:0] ld_mem [LD_DEPTH];
  logic [ADDR_W-1:0] st_mem [ST_DEPTH];
  logic [ST_DEPTH-1:0] st_vld;
  logic              raw_q;

  logic [ADDR_W-1:0] addr;
  logic              accept;
  logic              ld_push;
  logic              st_push;
  logic              ld_pop;
  logic              st_pop;
  logic              raw_match;

  assign addr    = instr_i[ADDR_W-1:0];
  assign ready_o = (ld_cnt < LCW'(LD_DEPTH)) &&
                   (st_cnt < SCW'(ST_DEPTH));
  assign accept  = instr_valid_i && ready_o;
  assign ld_push = accept && is_load_i;
  assign st_push = accept && !is_load_i;
  assign ld_pop  = load_mem_resp_i && (ld_cnt != '0);
  assign st_pop  = store_mem_resp_i && (st_cnt != '0);

  // Compare against entries valid before this cycle's update,
  // so a store popped now still counts and one pushed now does not.
  always_comb begin
    raw_match = 1'b0;
    for (int i = 0; i < int'(ST_DEPTH); i++) begin
      if (st_vld[i] && (st_mem[i] == addr)) raw_match = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (ld_push) ld_mem[ld_wr] <= addr;
    if (st_push) st_mem[st_wr] <= addr;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ld_cnt <= '0;
      ld_rd  <= '0;
      ld_wr  <= '0;
    end else begin
      if (ld_push) ld_wr <= (ld_wr == LD_LAST) ? '0 : ld_wr + LPW'(1);
      if (ld_pop)  ld_rd <= (ld_rd == LD_LAST) ? '0 : ld_rd + LPW'(1);
      unique case ({ld_push, ld_pop})
        2'b10:   ld_cnt <= ld_cnt + LCW'(1);
        2'b01:   ld_cnt <= ld_cnt - LCW'(1);
        default: ld_cnt <= ld_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      st_cnt <= '0;
      st_rd  <= '0;
      st_wr  <= '0;
      st_vld <= '0;
    end else begin
      if (st_push) st_wr <= (st_wr == ST_LAST) ? '0 : st_wr + SPW'(1);
      if (st_pop)  st_rd <= (st_rd == ST_LAST) ? '0 : st_rd + SPW'(1);
      if (st_pop)  st_vld[st_rd] <= 1'b0;
      if (st_push) st_vld[st_wr] <= 1'b1;
      unique case ({st_push, st_pop})
        2'b10:   st_cnt <= st_cnt + SCW'(1);
        2'b01:   st_cnt <= st_cnt - SCW'(1);
        default: st_cnt <= st_cnt;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) raw_q <= 1'b0;
    else         raw_q <= ld_push && raw_match;
  end

  assign ld_cnt_o        = ld_cnt;
  assign st_cnt_o        = st_cnt;
  assign ld_head_valid_o = (ld_cnt != '0);
  assign st_head_valid_o = (st_cnt != '0);
  assign ld_head_addr_o  = ld_mem[ld_rd];
  assign st_head_addr_o  = st_mem[st_rd];
  assign raw_hit_o       = raw_q;

`ifdef LSU_MO_MODEL_ERR_EN
  logic err_q;
  logic err_ev;

  assign err_ev = (load_mem_resp_i && (ld_cnt == '0)) ||
                  (store_mem_resp_i && (st_cnt == '0)) ||
                  (instr_valid_i && !ready_o);

  always_ff @(posedge clk_i) begin
    if (!rst_ni)     err_q <= 1'b0;
    else if (err_ev) err_q <= 1'b1;
  end

  assign error_o = err_q;
`else
  assign error_o = 1'b0;
`endif

endmodule
